// File: rtl/pipe_skid_latch.sv
// Two-entry pipeline skid latch between two pipeline stages.
// The head entry drives the downstream stage and the forwarding view.
// The skid entry absorbs one extra transfer while downstream is stalled.
// Every output comes straight from a flop. in_ready therefore depends only
// on held state, never on out_ready or in_valid in the same cycle.
// A saturating counter tracks how many cycles the head was back-pressured.
module pipe_skid_latch #(
  parameter int DW  = 96,
  parameter int SCW = 16
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DW-1:0]  in_data,
  input  logic           in_wen,
  input  logic [4:0]     in_rw,
  input  logic           flush,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  out_data,
  output logic           fwd_wen,
  output logic [4:0]     fwd_rw,
  output logic [1:0]     occ,
  output logic [SCW-1:0] stall_cnt
);

  // Occupancy encodings used throughout the next-state logic.
  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  // Saturating increment: the counter holds at all-ones instead of wrapping.
  function automatic logic [SCW-1:0] sat_inc(input logic [SCW-1:0] value);
    logic [SCW-1:0] result;
    if (value == {SCW{1'b1}}) begin
      result = value;
    end else begin
      result = value + SCW'(1);
    end
    return result;
  endfunction

  // Held state. An empty slot is kept all-zero, so the head flops can feed
  // the outputs directly and an empty latch shows a bubble.
  logic [DW-1:0]  head_data_r;
  logic           head_wen_r;
  logic [4:0]     head_rw_r;
  logic [DW-1:0]  skid_data_r;
  logic           skid_wen_r;
  logic [4:0]     skid_rw_r;
  logic [1:0]     occ_r;
  logic           out_valid_r;
  logic           in_ready_r;
  logic [SCW-1:0] stall_r;

  // Next-state values.
  logic [DW-1:0]  head_data_s;
  logic           head_wen_s;
  logic [4:0]     head_rw_s;
  logic [DW-1:0]  skid_data_s;
  logic           skid_wen_s;
  logic [4:0]     skid_rw_s;
  logic [1:0]     occ_s;
  logic [SCW-1:0] stall_s;

  // Handshake qualifiers. Flush overrides an incoming entry. A pop in the
  // flush cycle still counts, because downstream has already taken the head.
  logic push_s;
  logic pop_s;

  assign push_s = in_valid & in_ready_r & ~flush;
  assign pop_s  = out_valid_r & out_ready;

  // Slot movement: load, shift skid into head, or clear on flush.
  always_comb begin
    head_data_s = head_data_r;
    head_wen_s  = head_wen_r;
    head_rw_s   = head_rw_r;
    skid_data_s = skid_data_r;
    skid_wen_s  = skid_wen_r;
    skid_rw_s   = skid_rw_r;
    occ_s       = occ_r;

    if (flush || (occ_r == 2'd3)) begin
      // Squash, or recovery from an unreachable occupancy code.
      head_data_s = {DW{1'b0}};
      head_wen_s  = 1'b0;
      head_rw_s   = 5'd0;
      skid_data_s = {DW{1'b0}};
      skid_wen_s  = 1'b0;
      skid_rw_s   = 5'd0;
      occ_s       = OCC_EMPTY;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          // Push only: fill the first free slot.
          case (occ_r)
            OCC_EMPTY: begin
              head_data_s = in_data;
              head_wen_s  = in_wen;
              head_rw_s   = in_rw;
              occ_s       = OCC_ONE;
            end
            OCC_ONE: begin
              skid_data_s = in_data;
              skid_wen_s  = in_wen;
              skid_rw_s   = in_rw;
              occ_s       = OCC_FULL;
            end
            default: begin
              occ_s = occ_r;
            end
          endcase
        end
        2'b01: begin
          // Pop only: the skid entry, if any, moves up to head.
          case (occ_r)
            OCC_ONE: begin
              head_data_s = {DW{1'b0}};
              head_wen_s  = 1'b0;
              head_rw_s   = 5'd0;
              occ_s       = OCC_EMPTY;
            end
            OCC_FULL: begin
              head_data_s = skid_data_r;
              head_wen_s  = skid_wen_r;
              head_rw_s   = skid_rw_r;
              skid_data_s = {DW{1'b0}};
              skid_wen_s  = 1'b0;
              skid_rw_s   = 5'd0;
              occ_s       = OCC_ONE;
            end
            default: begin
              occ_s = occ_r;
            end
          endcase
        end
        2'b11: begin
          // Push and pop together: occupancy is unchanged and the queue
          // advances by one slot.
          case (occ_r)
            OCC_ONE: begin
              head_data_s = in_data;
              head_wen_s  = in_wen;
              head_rw_s   = in_rw;
            end
            OCC_FULL: begin
              head_data_s = skid_data_r;
              head_wen_s  = skid_wen_r;
              head_rw_s   = skid_rw_r;
              skid_data_s = in_data;
              skid_wen_s  = in_wen;
              skid_rw_s   = in_rw;
            end
            default: begin
              occ_s = occ_r;
            end
          endcase
        end
        default: begin
          occ_s = occ_r;
        end
      endcase
    end
  end

  // The stall counter advances whenever a valid head is refused downstream.
  // A flush does not clear it.
  always_comb begin
    if (out_valid_r && !out_ready) begin
      stall_s = sat_inc(stall_r);
    end else begin
      stall_s = stall_r;
    end
  end

  // State and registered outputs. Reset overrides flush, push and pop.
  always_ff @(posedge CLK) begin
    if (RST) begin
      head_data_r <= {DW{1'b0}};
      head_wen_r  <= 1'b0;
      head_rw_r   <= 5'd0;
      skid_data_r <= {DW{1'b0}};
      skid_wen_r  <= 1'b0;
      skid_rw_r   <= 5'd0;
      occ_r       <= OCC_EMPTY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      stall_r     <= {SCW{1'b0}};
    end else begin
      head_data_r <= head_data_s;
      head_wen_r  <= head_wen_s;
      head_rw_r   <= head_rw_s;
      skid_data_r <= skid_data_s;
      skid_wen_r  <= skid_wen_s;
      skid_rw_r   <= skid_rw_s;
      occ_r       <= occ_s;
      out_valid_r <= (occ_s != OCC_EMPTY);
      in_ready_r  <= (occ_s != OCC_FULL);
      stall_r     <= stall_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = head_data_r;
  assign fwd_wen   = head_wen_r;
  assign fwd_rw    = head_rw_r;
  assign occ       = occ_r;
  assign stall_cnt = stall_r;

endmodule

// File: tb/tb_pipe_skid_latch.sv
// Directed and randomized checks for pipe_skid_latch with a small stall
// counter, so that saturation is reachable in a short run.
module tb_pipe_skid_latch;

  localparam int DW  = 96;
  localparam int SCW = 4;
  localparam int SAT = 15;

  logic           CLK;
  logic           RST;
  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  in_data;
  logic           in_wen;
  logic [4:0]     in_rw;
  logic           flush;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_data;
  logic           fwd_wen;
  logic [4:0]     fwd_rw;
  logic [1:0]     occ;
  logic [SCW-1:0] stall_cnt;

  pipe_skid_latch #(.DW(DW), .SCW(SCW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_wen    (in_wen),
    .in_rw     (in_rw),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .fwd_wen   (fwd_wen),
    .fwd_rw    (fwd_rw),
    .occ       (occ),
    .stall_cnt (stall_cnt)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [DW-1:0] d;
    logic          w;
    logic [4:0]    rw;
  } ent_t;

  ent_t q[$];
  int   stall_m;
  int   n_cmp;
  int   n_err;

  localparam logic [DW-1:0] VA = 96'hAAAA_0001_1111_2222_3333_4444;
  localparam logic [DW-1:0] VB = 96'hBBBB_0002_5555_6666_7777_8888;
  localparam logic [DW-1:0] VC = 96'hCCCC_0003_9999_AAAA_BBBB_CCCC;
  localparam logic [DW-1:0] VD = 96'hDDDD_0004_DEAD_BEEF_CAFE_F00D;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic w,
                       input logic [4:0] rw, input logic f, input logic rdy);
    in_valid  = v;
    in_data   = d;
    in_wen    = w;
    in_rw     = rw;
    flush     = f;
    out_ready = rdy;
  endtask

  // One rising edge. The reference queue is advanced alongside it, and the
  // outputs are sampled 1 time unit after the edge.
  task automatic tick();
    bit   push_m;
    bit   pop_m;
    bit   stall_m_inc;
    ent_t e;
    push_m      = in_valid && (q.size() != 2) && !flush;
    pop_m       = (q.size() != 0) && out_ready;
    stall_m_inc = (q.size() != 0) && !out_ready;
    e.d  = in_data;
    e.w  = in_wen;
    e.rw = in_rw;
    @(posedge CLK);
    #1;
    if (RST) begin
      q.delete();
      stall_m = 0;
    end else begin
      if (pop_m) void'(q.pop_front());
      if (flush) q.delete();
      else if (push_m) q.push_back(e);
      if (stall_m_inc && stall_m < SAT) stall_m++;
    end
  endtask

  // Compare every output against the reference queue.
  task automatic check_model(input string tag);
    logic [DW-1:0] ed;
    logic          ew;
    logic [4:0]    er;
    if (q.size() != 0) begin
      ed = q[0].d;
      ew = q[0].w;
      er = q[0].rw;
    end else begin
      ed = '0;
      ew = 1'b0;
      er = 5'd0;
    end
    check_eq({tag, "_valid"}, 128'(out_valid), 128'(q.size() != 0));
    check_eq({tag, "_ready"}, 128'(in_ready),  128'(q.size() != 2));
    check_eq({tag, "_occ"},   128'(occ),       128'(q.size()));
    check_eq({tag, "_data"},  128'(out_data),  128'(ed));
    check_eq({tag, "_wen"},   128'(fwd_wen),   128'(ew));
    check_eq({tag, "_rw"},    128'(fwd_rw),    128'(er));
    check_eq({tag, "_stall"}, 128'(stall_cnt), 128'(stall_m));
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    stall_m = 0;
    RST     = 1'b1;
    drive(1'b0, '0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    tick();
    RST = 1'b0;

    // Reset state.
    check_eq("rst_valid", 128'(out_valid), 128'(0));
    check_eq("rst_ready", 128'(in_ready),  128'(1));
    check_eq("rst_occ",   128'(occ),       128'(0));
    check_eq("rst_data",  128'(out_data),  128'(0));
    check_eq("rst_fwd",   128'({fwd_wen, fwd_rw}), 128'(0));
    check_eq("rst_stall", 128'(stall_cnt), 128'(0));

    // Single pass-through with one cycle of latency.
    drive(1'b1, VA, 1'b1, 5'd5, 1'b0, 1'b1);
    tick();
    check_eq("pass_valid", 128'(out_valid), 128'(1));
    check_eq("pass_data",  128'(out_data),  128'(VA));
    check_eq("pass_rw",    128'(fwd_rw),    128'(5));
    check_eq("pass_wen",   128'(fwd_wen),   128'(1));
    drive(1'b0, '0, 1'b0, 5'd0, 1'b0, 1'b1);
    tick();
    check_eq("pass_occ0",  128'(occ),       128'(0));
    check_eq("pass_bub",   128'(out_data),  128'(0));
    check_eq("pass_wen0",  128'(fwd_wen),   128'(0));

    // Fill both slots under back-pressure, then drain them in order.
    drive(1'b1, VA, 1'b0, 5'd3, 1'b0, 1'b0);
    tick();
    drive(1'b1, VB, 1'b1, 5'd7, 1'b0, 1'b0);
    tick();
    check_eq("full_occ",   128'(occ),       128'(2));
    check_eq("full_ready", 128'(in_ready),  128'(0));
    check_eq("full_data",  128'(out_data),  128'(VA));
    check_eq("full_stall", 128'(stall_cnt), 128'(1));
    drive(1'b1, VC, 1'b1, 5'd9, 1'b0, 1'b0);
    tick();
    check_eq("hold_data",  128'(out_data),  128'(VA));
    check_eq("hold_rw",    128'(fwd_rw),    128'(3));
    check_eq("hold_occ",   128'(occ),       128'(2));
    check_eq("hold_stall", 128'(stall_cnt), 128'(2));
    drive(1'b0, '0, 1'b0, 5'd0, 1'b0, 1'b1);
    tick();
    check_eq("drain1_data",  128'(out_data), 128'(VB));
    check_eq("drain1_rw",    128'(fwd_rw),   128'(7));
    check_eq("drain1_ready", 128'(in_ready), 128'(1));
    check_eq("drain1_occ",   128'(occ),      128'(1));
    tick();
    check_eq("drain2_occ",   128'(occ),      128'(0));
    check_eq("drain2_stall", 128'(stall_cnt), 128'(2));

    // Push and pop in the same cycle at occupancy 1.
    drive(1'b1, VA, 1'b1, 5'd1, 1'b0, 1'b0);
    tick();
    drive(1'b1, VC, 1'b0, 5'd12, 1'b0, 1'b1);
    tick();
    check_eq("pp_occ",  128'(occ),      128'(1));
    check_eq("pp_data", 128'(out_data), 128'(VC));
    check_eq("pp_rw",   128'(fwd_rw),   128'(12));
    check_eq("pp_wen",  128'(fwd_wen),  128'(0));
    drive(1'b0, '0, 1'b0, 5'd0, 1'b0, 1'b1);
    tick();

    // Flush while full with a competing push: everything is dropped.
    drive(1'b1, VA, 1'b1, 5'd2, 1'b0, 1'b0);
    tick();
    drive(1'b1, VB, 1'b1, 5'd4, 1'b0, 1'b0);
    tick();
    check_eq("prefl_stall", 128'(stall_cnt), 128'(3));
    drive(1'b1, VD, 1'b1, 5'd6, 1'b1, 1'b1);
    tick();
    check_eq("fl_occ",   128'(occ),       128'(0));
    check_eq("fl_valid", 128'(out_valid), 128'(0));
    check_eq("fl_data",  128'(out_data),  128'(0));
    check_eq("fl_stall", 128'(stall_cnt), 128'(3));
    drive(1'b0, '0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    check_eq("fl_after", 128'(occ), 128'(0));

    // Saturate the stall counter, then reset in the middle of operation.
    drive(1'b1, VA, 1'b1, 5'd8, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    check_eq("sat_stall", 128'(stall_cnt), 128'(15));
    check_eq("sat_data",  128'(out_data),  128'(VA));
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check_eq("mrst_stall", 128'(stall_cnt), 128'(0));
    check_eq("mrst_occ",   128'(occ),       128'(0));
    check_eq("mrst_ready", 128'(in_ready),  128'(1));

    // Random traffic compared against the reference queue.
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)),
            {$urandom, $urandom, $urandom},
            1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 2) != 0));
      tick();
      check_model("rnd");
      if (n_err > 20) break;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_skid_latch.md
PIPE_SKID_LATCH -- requirements
Module: pipe_skid_latch

Interface
REQ-001 SHALL take parameter DW, default 96, width of the stage payload (control plus data word fields).
REQ-002 SHALL take parameter SCW, default 16, width of the stall counter.
REQ-003 SHALL have port CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  in  1  upstream stage offers an entry.
REQ-006 SHALL have port in_ready  out  1  latch can accept an entry this cycle.
REQ-007 SHALL have port in_data  in  DW  upstream payload.
REQ-008 SHALL have port in_wen  in  1  entry writes the register file.
REQ-009 SHALL have port in_rw  in  5  entry destination register.
REQ-010 SHALL have port flush  in  1  discard all held entries (branch or jump squash).
REQ-011 SHALL have port out_valid  out  1  head entry present.
REQ-012 SHALL have port out_ready  in  1  downstream stage consumes head this cycle.
REQ-013 SHALL have port out_data  out  DW  head payload.
REQ-014 SHALL have port fwd_wen  out  1  head writes register file (forwarding view).
REQ-015 SHALL have port fwd_rw  out  5  head destination register (forwarding view).
REQ-016 SHALL have port occ  out  2  entries held, 0..2.
REQ-017 SHALL have port stall_cnt  out  SCW  saturating count of back-pressured cycles.

Function
REQ-018 SHALL hold at most 2 entries (head plus skid) in FIFO order; each entry stores data, wen, rw.
REQ-019 SHALL drive in_ready = (occ != 2), from registered state only; no combinational path from out_ready or in_valid to in_ready.
REQ-020 SHALL define push = in_valid & in_ready & ~flush, and pop = out_valid & out_ready.
REQ-021 SHALL have latency 1: an entry pushed in cycle N is visible at out_* in cycle N+1 at the earliest; no same-cycle bypass.
REQ-022 SHALL update occ as follows: push only +1; pop only -1; push and pop together unchanged, with the skid entry (or the new entry when occ=1) becoming head.
REQ-023 SHALL keep out_data, fwd_wen, fwd_rw stable while out_valid=1 and out_ready=0.
REQ-024 SHALL drive out_valid = (occ != 0); when occ=0, out_data SHALL be all zeros (bubble), fwd_wen=0, and fwd_rw=0.
REQ-025 SHALL drive fwd_wen = out_valid & head wen.
REQ-026 SHALL, on flush=1, set occ to 0 next cycle; flush beats push; a pop in the flush cycle still counts as transferred downstream.
REQ-027 SHALL never lose, duplicate, or reorder entries when flush=0.
REQ-028 SHALL increment stall_cnt by 1 in every cycle with out_valid=1 and out_ready=0, saturating at 2^SCW-1 with no wrap; flush SHALL NOT clear it.

Reset
REQ-029 SHALL, while RST=1 at a rising edge, set occ=0 and stall_cnt=0, giving out_valid=0, in_ready=1, out_data=0, fwd_wen=0, fwd_rw=0 next cycle.
REQ-030 SHALL give RST priority over flush, push, and pop; reset in mid-operation discards held entries.

Verification
REQ-031 SHALL cover: reset, then push A (in_rw=5, in_wen=1) with out_ready=1 -> next cycle out_valid=1, out_data=A, fwd_rw=5, fwd_wen=1; following cycle occ=0, out_data=0.
REQ-032 SHALL cover: out_ready=0, push A then B -> occ=2, in_ready=0, out_data=A held; raise out_ready -> A then B on consecutive cycles, in_ready=1 after the first pop.
REQ-033 SHALL cover: occ=1 (A), push C and pop in the same cycle -> occ stays 1, out_data=C next cycle.
REQ-034 SHALL cover: occ=2, flush=1 with in_valid=1 -> occ=0 next cycle, new entry dropped, out_valid=0, stall_cnt unchanged.
REQ-035 SHALL cover: SCW=4, out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15, no wrap; RST=1 -> stall_cnt=0 next cycle.
REQ-036 SHALL cover: random in_valid/out_ready/flush for 10k cycles against a scoreboard -> order preserved, no loss outside flush, occ never exceeds 2.
